btn_debounce_pulse: RTL and testbench

- Upstream conditioning stage for the 4-bit binary up counter.
- Takes a raw, bouncing, asynchronous push-button input and synchronises it to clk.
- Debounces it with a stability-count FSM.
- Emits a single-cycle press_pulse that drives the counter's increment enable, plus a clean level and a release_pulse.

---
 rtl/btn_debounce_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 13 +
 rtl/btn_debounce_pulse.sv | 95 +++++++++
 tb/tb_btn_debounce_pulse.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: shared FSM encoding, timing defaults and counter width helper
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY  = 50000000;
    localparam int DEF_REPEAT_PERIOD = 10000000;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous bit
// Ports: clk, rst_n (async active-low, clears both flops), d (async input), q (synchronised output)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronise, debounce and edge-pulse a raw push button
// Ports: clk, rst_n (async active-low), btn_in (raw async button, active-high),
//        btn_level (debounced level), press_pulse (1-cycle accepted press / auto-repeat),
//        release_pulse (1-cycle accepted release)
// Optional: define BTN_DEBOUNCE_AUTOREPEAT_EN for periodic press_pulse while held.
module btn_debounce_pulse
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int CNT_W = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             btn_sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(btn_in), .q(btn_sync));

    // saturating increment: an overflow holds instead of wrapping
    always_comb cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
    logic rep_phase;
    logic rep_hit;
    always_comb rep_hit = cnt == (rep_phase ? REPEAT_NEXT : REPEAT_FIRST);
    // rep_phase marks that the initial delay has elapsed; any exit from HELD clears it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rep_phase <= 1'b0;
        else        rep_phase <= state == HELD && btn_sync && (rep_phase || rep_hit);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE:
                    if (btn_sync) begin
                        state <= ARM_PRESS;
                        cnt   <= '0;
                    end
                ARM_PRESS:
                    if (!btn_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= HELD;
                        cnt         <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else cnt <= cnt_inc;
                HELD:
                    if (!btn_sync) begin
                        state <= ARM_RELEASE;
                        cnt   <= '0;
                    end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    else if (rep_hit) begin
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                    end else cnt <= cnt_inc;
`endif
                ARM_RELEASE:
                    if (btn_sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else cnt <= cnt_inc;
            endcase
        end
    end
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: scoreboard bench for btn_debounce_pulse with short timing parameters
module tb_btn_debounce_pulse;
    localparam int S    = 4;
    localparam int RD   = 8;
    localparam int RP   = 3;
    localparam int HOLD = 30;

    typedef struct {
        bit press;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, press_pulse, release_pulse;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [3:0] cnt4 = 4'd0;
    logic [3:0] base;
    int p;
    exp_t sb[$];

    btn_debounce_pulse #(.STABLE_CYCLES(S), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (press_pulse) cnt4 <= cnt4 + 4'd1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input bit press, input int at);
        sb.push_back('{press, at});
    endtask

    // pops expectations as pulses appear; a pulse with no expectation, or an overdue one, is a failure
    always @(negedge clk) if (rst_n) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed_pulse", cyc, sb[0].cyc);
            sb.delete(0);
        end
        if (press_pulse || release_pulse) begin
            check("both_pulses", {31'd0, press_pulse & release_pulse}, 0);
            if (sb.size() == 0) check("unexpected_pulse", {30'd0, press_pulse, release_pulse}, 0);
            else begin
                check("pulse_kind", {31'd0, press_pulse}, {31'd0, sb[0].press});
                check("pulse_cycle", cyc, sb[0].cyc);
                sb.delete(0);
            end
        end
    end

    initial begin
        step(2);
        check("rst_level", btn_level, 0);
        check("rst_press", press_pulse, 0);
        check("rst_release", release_pulse, 0);
        rst_n = 1'b1;
        step(2);

        // clean press: pulse and level together after edge S+3
        btn_in = 1'b1;
        expect_pulse(1, cyc + S + 3);
        step(S + 2);
        check("press_early_level", btn_level, 0);
        step(1);
        check("press_level", btn_level, 1);
        check("press_pulse", press_pulse, 1);
        step(1);
        check("press_pulse_width", press_pulse, 0);
        check("press_level_hold", btn_level, 1);

        // release bounce then stable release
        btn_in = 1'b0;
        step(2);
        btn_in = 1'b1;
        step(6);
        check("bounce_level", btn_level, 1);
        btn_in = 1'b0;
        expect_pulse(0, cyc + S + 3);
        step(S + 2);
        check("release_early_level", btn_level, 1);
        step(1);
        check("release_pulse", release_pulse, 1);
        check("release_level", btn_level, 0);
        step(1);
        check("release_pulse_width", release_pulse, 0);

        // glitch shorter than the stability window
        btn_in = 1'b1;
        step(3);
        btn_in = 1'b0;
        step(8);
        check("glitch_level", btn_level, 0);

        // reset mid-arm, button still held through reset release
        btn_in = 1'b1;
        step(4);
        rst_n = 1'b0;
        #1;
        check("rst_arm_level", btn_level, 0);
        check("rst_arm_press", press_pulse, 0);
        check("rst_arm_release", release_pulse, 0);
        @(negedge clk);
        step(1);
        rst_n = 1'b1;
        expect_pulse(1, cyc + S + 3);
        step(S + 3);
        check("rst_fresh_press", press_pulse, 1);
        step(1);
        rst_n = 1'b0;
        #1;
        check("rst_held_level", btn_level, 0);
        btn_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4);

        // long hold: auto-repeat pulses only when the feature is built in
        btn_in = 1'b1;
        p = cyc + S + 3;
        expect_pulse(1, p);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        for (int k = p + RD; k <= p + HOLD + 2; k += RP) expect_pulse(1, k);
`endif
        step(S + 3);
        step(HOLD);
        check("hold_level", btn_level, 1);
        btn_in = 1'b0;
        expect_pulse(0, cyc + S + 3);
        step(S + 4);
        check("hold_release_level", btn_level, 0);

        // integration: 17 accepted presses into a 4-bit counter
        base = cnt4;
        for (int i = 0; i < 17; i++) begin
            btn_in = 1'b1;
            expect_pulse(1, cyc + S + 3);
            step(S + 3);
            btn_in = 1'b0;
            expect_pulse(0, cyc + S + 3);
            step(S + 4);
        end
        check("counter_wrap", {28'd0, 4'(cnt4 - base)}, 1);

        step(4);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
